// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: opcodes,
// ALU operation codes, FSM states, datapath mux selects and opcode classification.
package mips_ctrl_pkg;

    localparam int unsigned OP_R     = 0;
    localparam int unsigned OP_J     = 2;
    localparam int unsigned OP_JAL   = 3;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_BNE   = 5;
    localparam int unsigned OP_ADDI  = 8;
    localparam int unsigned OP_SLTI  = 10;
    localparam int unsigned OP_SLTIU = 11;
    localparam int unsigned OP_ANDI  = 12;
    localparam int unsigned OP_ORI   = 13;
    localparam int unsigned OP_XORI  = 14;
    localparam int unsigned OP_LUI   = 15;
    localparam int unsigned OP_LW    = 35;
    localparam int unsigned OP_SW    = 43;
    localparam int unsigned FN_JR    = 8;

    localparam logic [3:0] ALU_NONE   = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SUB_EQ = 4'd5;
    localparam logic [3:0] ALU_SUB_NE = 4'd6;
    localparam logic [3:0] ALU_SLT    = 4'd7;
    localparam logic [3:0] ALU_SLTU   = 4'd8;
    localparam logic [3:0] ALU_LUI    = 4'd9;
    localparam logic [3:0] ALU_FUNCT  = 4'd15;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_BROFF = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REGA   = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_JUMP_REG
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_JR,
        CL_IARITH,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_ILLEGAL
    } op_class_t;

    // Operands arrive zero-extended to 32 bits so any opcode/funct width compares cleanly.
    function automatic op_class_t classify(input logic [31:0] op, input logic [31:0] fn);
        op_class_t cls;
        case (op)
            OP_R:                            cls = (fn == FN_JR) ? CL_JR : CL_R;
            OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls = CL_IARITH;
            OP_LW:                           cls = CL_LOAD;
            OP_SW:                           cls = CL_STORE;
            OP_BEQ, OP_BNE:                  cls = CL_BRANCH;
            OP_J, OP_JAL:                    cls = CL_JUMP;
            default:                         cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] iarith_alu(input logic [31:0] op);
        logic [3:0] code;
        case (op)
            OP_ANDI:  code = ALU_AND;
            OP_ORI:   code = ALU_OR;
            OP_XORI:  code = ALU_XOR;
            OP_SLTI:  code = ALU_SLT;
            OP_SLTIU: code = ALU_SLTU;
            OP_LUI:   code = ALU_LUI;
            default:  code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic iarith_zext(input logic [31:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller, the instruction register,
// the unified memory handshake and the datapath mux/strobe inputs.
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                mem_ready;

    logic                pc_write;
    logic                pc_write_cond;
    logic                ir_write;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          mem_to_reg;
    logic [1:0]          reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                ext_zero;
    logic [ALUOP_W-1:0]  alu_op;
    logic [1:0]          pc_src;
    logic                branch_ne;
    logic                instr_done;
    logic                illegal;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero,
               alu_op, pc_src, branch_ne, instr_done, illegal
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero,
               alu_op, pc_src, branch_ne, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational output decode: maps the current state plus opcode/funct to the
// datapath control bundle; everything is forced low while inactive (in reset).
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 4
) (
    input  logic                active,
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    output op_class_t           op_class,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          mem_to_reg,
    output logic [1:0]          reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_zero,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                branch_ne,
    output logic                instr_done,
    output logic                illegal
);

    logic [31:0] op_ext;
    logic [31:0] fn_ext;
    logic [3:0]  alu_code;

    assign op_ext   = 32'(opcode);
    assign fn_ext   = 32'(funct);
    assign op_class = classify(op_ext, fn_ext);
    assign alu_op   = ALUOP_W'(alu_code);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = M2R_ALUOUT;
        reg_dst       = DST_RT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        ext_zero      = 1'b0;
        alu_code      = ALU_NONE;
        pc_src        = PCS_ALU;
        branch_ne     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        if (active) begin
            case (state)
                S_FETCH: begin
                    // PC+4 is computed every fetch cycle; it only lands when memory is ready.
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_code  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_BROFF;
                    alu_code  = ALU_ADD;
                    if (op_class == CL_ILLEGAL) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REGB;
                    alu_code  = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_zero  = iarith_zext(op_ext);
                    alu_code  = iarith_alu(op_ext);
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_code  = ALU_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_ALUOUT;
                    reg_dst    = (op_class == CL_R) ? DST_RD : DST_RT;
                    instr_done = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    reg_dst    = DST_RT;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_REGB;
                    alu_code      = (op_ext == OP_BNE) ? ALU_SUB_NE : ALU_SUB_EQ;
                    pc_write_cond = 1'b1;
                    pc_src        = PCS_ALUOUT;
                    branch_ne     = (op_ext == OP_BNE);
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PCS_JUMP;
                    instr_done = 1'b1;
                    // jal links PC (already advanced in FETCH) into $31.
                    if (op_ext == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
                S_JUMP_REG: begin
                    pc_write   = 1'b1;
                    pc_src     = PCS_REGA;
                    instr_done = 1'b1;
                end
                default: begin
                    alu_code = ALU_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: registered instruction-sequencing FSM; the output
// bundle is decoded combinationally from the state and the current IR fields.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t    state_reg;
    state_t    state_next;
    op_class_t op_class;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_class)
                    CL_R:              state_next = S_EXEC_R;
                    CL_JR:             state_next = S_JUMP_REG;
                    CL_IARITH:         state_next = S_EXEC_I;
                    CL_LOAD, CL_STORE: state_next = S_ADDR;
                    CL_BRANCH:         state_next = S_BRANCH;
                    CL_JUMP:           state_next = S_JUMP;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_ADDR: begin
                state_next = (op_class == CL_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            // Memory states hold until the handshake completes.
            S_MEM_RD: begin
                if (bus.mem_ready) begin
                    state_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALUOP_W  (ALUOP_W)
    ) u_decode (
        .active        (rst_n),
        .state         (state_reg),
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .mem_ready     (bus.mem_ready),
        .op_class      (op_class),
        .pc_write      (bus.pc_write),
        .pc_write_cond (bus.pc_write_cond),
        .ir_write      (bus.ir_write),
        .iord          (bus.iord),
        .mem_read      (bus.mem_read),
        .mem_write     (bus.mem_write),
        .mem_to_reg    (bus.mem_to_reg),
        .reg_dst       (bus.reg_dst),
        .reg_write     (bus.reg_write),
        .alu_src_a     (bus.alu_src_a),
        .alu_src_b     (bus.alu_src_b),
        .ext_zero      (bus.ext_zero),
        .alu_op        (bus.alu_op),
        .pc_src        (bus.pc_src),
        .branch_ne     (bus.branch_ne),
        .instr_done    (bus.instr_done),
        .illegal       (bus.illegal)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a memory/IR driver issues
// instructions with random wait states, a monitor summarizes each instruction.
module tb_multicycle_control;

    localparam int N_INSTR   = 60;
    localparam int MAX_CYCLE = 20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4)) bus ();

    multicycle_control #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [23:0] all_outs;
    assign all_outs = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.iord,
                       bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_dst,
                       bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.ext_zero,
                       bus.alu_op, bus.pc_src, bus.branch_ne, bus.instr_done, bus.illegal};

    typedef struct {
        int op;     int fn;
        int cycles; int mem_rd; int mem_wr;
        int rw;     int rw_dst; int rw_m2r;
        int pcw;    int irw;    int pcwc;   int bne; int pcs;
        int srca;   int aluop;  int ezero;  int ill; int fetch_bad;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   op_tab [20] = '{0, 0, 0, 8, 12, 13, 14, 4, 5, 10, 11, 15, 35, 43, 2, 3, 63, 1, 20, 50};

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (instr %0d): got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Reference behaviour per instruction, from the ISA rules and wait counts.
    function automatic rec_t expect_rec(input int op, input int fn, input int wf, input int wm);
        rec_t r;
        bit is_r, is_jr, iar, lw, sw, br, jmp, ill;
        r      = '{default: 0};
        r.op   = op;
        r.fn   = fn;
        is_r   = (op == 0) && (fn != 8);
        is_jr  = (op == 0) && (fn == 8);
        iar    = (op == 8) || (op >= 10 && op <= 15);
        lw     = (op == 35);
        sw     = (op == 43);
        br     = (op == 4) || (op == 5);
        jmp    = (op == 2) || (op == 3);
        ill    = !(is_r || is_jr || iar || lw || sw || br || jmp);
        r.cycles = (wf + 1) + 1;
        if (is_r || iar)            r.cycles += 2;
        else if (br || jmp || is_jr) r.cycles += 1;
        else if (lw)                r.cycles += 1 + (wm + 1) + 1;
        else if (sw)                r.cycles += 1 + (wm + 1);
        r.mem_rd = (wf + 1) + (lw ? wm + 1 : 0);
        r.mem_wr = sw ? wm + 1 : 0;
        r.rw     = (is_r || iar || lw || op == 3) ? 1 : 0;
        r.rw_dst = is_r ? 1 : (op == 3) ? 2 : 0;
        r.rw_m2r = lw ? 1 : (op == 3) ? 2 : 0;
        r.pcw    = 1 + ((jmp || is_jr) ? 1 : 0);
        r.irw    = 1;
        r.pcwc   = br ? 1 : 0;
        r.bne    = (op == 5) ? 1 : 0;
        r.pcs    = br ? 1 : jmp ? 2 : is_jr ? 3 : 0;
        r.srca   = (is_r || iar || lw || sw || br) ? 1 : 0;
        case (op)
            0:       r.aluop = is_r ? 15 : 0;
            8:       r.aluop = 1;
            12:      r.aluop = 2;
            13:      r.aluop = 3;
            14:      r.aluop = 4;
            10:      r.aluop = 7;
            11:      r.aluop = 8;
            15:      r.aluop = 9;
            35, 43:  r.aluop = 1;
            4:       r.aluop = 5;
            5:       r.aluop = 6;
            default: r.aluop = 0;
        endcase
        r.ezero = (op == 12 || op == 13 || op == 14) ? 1 : 0;
        r.ill   = ill ? 1 : 0;
        return r;
    endfunction

    task automatic pick(output int op, output int fn, output int wf, output int wm);
        op = op_tab[$urandom_range(0, 19)];
        fn = (op == 0 && $urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 63));
        wf = $urandom_range(0, 2);
        wm = $urandom_range(0, 3);
    endtask

    // Monitor: accumulate one instruction's activity, compare on instr_done.
    initial begin : monitor
        rec_t obs;
        rec_t e;
        int   n_done;
        obs    = '{default: 0};
        n_done = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n !== 1'b1) begin
                obs = '{default: 0};
            end else begin
                obs.cycles++;
                if (bus.mem_read)      obs.mem_rd++;
                if (bus.mem_write)     obs.mem_wr++;
                if (bus.reg_write) begin
                    obs.rw++;
                    obs.rw_dst = int'(bus.reg_dst);
                    obs.rw_m2r = int'(bus.mem_to_reg);
                end
                if (bus.pc_write)      obs.pcw++;
                if (bus.ir_write)      obs.irw++;
                if (bus.ir_write && !(bus.alu_src_b == 2'd1 && bus.alu_op == 4'd1 &&
                    bus.pc_src == 2'd0 && !bus.iord && bus.mem_read)) obs.fetch_bad++;
                if (bus.pc_write_cond) obs.pcwc++;
                if (bus.branch_ne)     obs.bne++;
                if ((bus.pc_write && !bus.ir_write) || bus.pc_write_cond) obs.pcs = int'(bus.pc_src);
                if (bus.alu_src_a) begin
                    obs.srca++;
                    obs.aluop = int'(bus.alu_op);
                    obs.ezero = int'(bus.ext_zero);
                end
                if (bus.illegal)       obs.ill++;
                if (bus.instr_done) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got instr_done=1 expected no instruction in flight");
                    end else begin
                        e = exp_q.pop_front();
                        $display("instr %0d op=%0d fn=%0d cycles=%0d (exp %0d)",
                                 n_done, e.op, e.fn, obs.cycles, e.cycles);
                        chk("cycles",      n_done, obs.cycles,    e.cycles);
                        chk("mem_rd_cyc",  n_done, obs.mem_rd,    e.mem_rd);
                        chk("mem_wr_cyc",  n_done, obs.mem_wr,    e.mem_wr);
                        chk("reg_write",   n_done, obs.rw,        e.rw);
                        chk("reg_dst",     n_done, obs.rw_dst,    e.rw_dst);
                        chk("mem_to_reg",  n_done, obs.rw_m2r,    e.rw_m2r);
                        chk("pc_write",    n_done, obs.pcw,       e.pcw);
                        chk("ir_write",    n_done, obs.irw,       e.irw);
                        chk("pc_wr_cond",  n_done, obs.pcwc,      e.pcwc);
                        chk("branch_ne",   n_done, obs.bne,       e.bne);
                        chk("pc_src",      n_done, obs.pcs,       e.pcs);
                        chk("alu_src_a",   n_done, obs.srca,      e.srca);
                        chk("alu_op",      n_done, obs.aluop,     e.aluop);
                        chk("ext_zero",    n_done, obs.ezero,     e.ezero);
                        chk("illegal",     n_done, obs.ill,       e.ill);
                        chk("fetch_ctrl",  n_done, obs.fetch_bad, e.fetch_bad);
                    end
                    n_done++;
                    obs = '{default: 0};
                end
            end
        end
    end

    // Driver: plays IR and unified memory, choosing wait states per request.
    initial begin : driver
        int  p_op, p_fn, p_wf, p_wm;
        int  fetch_left, mem_left, issued, cyc, abort_wr;
        bit  aborting, finished;

        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.mem_ready = 1'b1;
        #3;
        chk("reset_outs_ready_hi", -1, int'(all_outs), 0);
        bus.mem_ready = 1'b0;
        #1;
        chk("reset_outs_ready_lo", -1, int'(all_outs), 0);

        pick(p_op, p_fn, p_wf, p_wm);
        fetch_left = p_wf;
        mem_left   = 0;
        issued     = 0;
        cyc        = 0;
        abort_wr   = 0;
        aborting   = 1'b0;
        finished   = 1'b0;

        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        while (!finished && cyc < MAX_CYCLE) begin
            if (bus.mem_read && !bus.iord) begin
                if (fetch_left > 0) begin
                    bus.mem_ready = 1'b0;
                    fetch_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                    bus.opcode    = 6'(p_op);
                    bus.funct     = 6'(p_fn);
                    mem_left      = p_wm;
                    if (issued < N_INSTR) begin
                        exp_q.push_back(expect_rec(p_op, p_fn, p_wf, p_wm));
                        issued++;
                        if (issued == N_INSTR) begin
                            p_op = 43; p_fn = 0; p_wf = 0; p_wm = 50;
                        end else begin
                            pick(p_op, p_fn, p_wf, p_wm);
                        end
                        fetch_left = p_wf;
                    end else begin
                        aborting = 1'b1;
                    end
                end
            end else if (bus.iord && (bus.mem_read || bus.mem_write)) begin
                if (mem_left > 0) begin
                    bus.mem_ready = 1'b0;
                    mem_left--;
                end else begin
                    bus.mem_ready = 1'b1;
                end
                if (aborting && bus.mem_write) begin
                    abort_wr++;
                    if (abort_wr == 3) begin
                        // Reset lands mid-wait, well clear of the clock edges.
                        #3 rst_n = 1'b0;
                        #1;
                        chk("abort_mem_write", -1, int'(bus.mem_write), 0);
                        chk("abort_all_outs",  -1, int'(all_outs), 0);
                        chk("sb_drained",      -1, exp_q.size(), 0);
                        finished = 1'b1;
                    end
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end

        if (!finished) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d cycles expected completion within %0d", cyc, MAX_CYCLE);
        end else begin
            bus.mem_ready = 1'b0;
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            #2;
            chk("post_reset_mem_read",  -1, int'(bus.mem_read), 1);
            chk("post_reset_iord",      -1, int'(bus.iord), 0);
            chk("post_reset_mem_write", -1, int'(bus.mem_write), 0);
            chk("post_reset_ir_write",  -1, int'(bus.ir_write), 0);
            repeat (3) @(negedge clk);
            #3;
            chk("post_reset_no_done",   -1, int'(bus.instr_done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the MIPS-subset datapath. It is the parametrised successor of the single-cycle decoder. A registered state machine sequences each instruction over 3–5 cycles plus memory wait states, sharing one ALU and one memory port. It sits between the instruction register (opcode/funct) and the multicycle datapath muxes, and handshakes with the unified memory through `mem_ready`.

## Interface
- `OPCODE_W`, default 6: opcode width.
- `FUNCT_W`, default 6: funct width.
- `ALUOP_W`, default 4: ALU operation code width.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  OPCODE_W: IR[31:26]. Valid from DECODE onward.
- `funct`  in  FUNCT_W: IR[5:0].
- `mem_ready`  in  1: memory completes the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`  out  1 each: PC and IR write strobes.
- `iord`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each: memory request; held until `mem_ready`.
- `mem_to_reg`  out  2: register write-data select. 0 = ALUOut, 1 = MDR, 2 = PC.
- `reg_dst`  out  2: destination register select. 0 = rt, 1 = rd, 2 = $31.
- `reg_write`  out  1: register file write enable.
- `alu_src_a`  out  1: ALU A select. 0 = PC, 1 = reg A.
- `alu_src_b`  out  2: ALU B select. 0 = reg B, 1 = 4, 2 = extended imm, 3 = sign-extended imm<<2.
- `ext_zero`  out  1: zero-extend the immediate (andi/ori/xori).
- `alu_op`  out  ALUOP_W: ALU operation code.
- `pc_src`  out  2: next-PC select. 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A.
- `branch_ne`  out  1: invert the zero test for bne.
- `instr_done`  out  1: one-cycle pulse in the last cycle of each instruction.
- `illegal`  out  1: one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes: R = 0 (funct 8 = jr), addi 8, andi 12, ori 13, xori 14, beq 4, bne 5, slti 10, sltiu 11, lui 15, lw 35, sw 43, j 2, jal 3.
- ALU codes:
  - ADD 1, AND 2, OR 3, XOR 4, SUB_EQ 5, SUB_NE 6, SLT 7, SLTU 8, LUI 9, FUNCT 15.
  - lw/sw use ADD.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JUMP_REG.
- Every output not listed for a state is 0.
- FETCH:
  - Asserts `mem_read`, `iord` = 0, `alu_src_a` = 0, `alu_src_b` = 1, `alu_op` = ADD, `pc_src` = 0.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready` = 1; that cycle transitions to DECODE.
- DECODE:
  - Computes the branch target: `alu_src_a` = 0, `alu_src_b` = 3, ADD.
  - Next state by opcode:
    - R → EXEC_R; R with funct 8 → JUMP_REG.
    - I-arith → EXEC_I.
    - lw/sw → ADDR.
    - beq/bne → BRANCH.
    - j/jal → JUMP.
    - Other → FETCH, with `illegal` and `instr_done` pulsed.
- EXEC_R: `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = FUNCT → WB_ALU.
- EXEC_I: `alu_src_a` = 1, `alu_src_b` = 2, `ext_zero` per opcode, code per table → WB_ALU.
- WB_ALU: `reg_write` = 1, `mem_to_reg` = 0, `reg_dst` = 1 for R, otherwise 0 → FETCH.
- ADDR: `alu_src_a` = 1, `alu_src_b` = 2, ADD → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_read`, `iord` = 1. Waits for `mem_ready`, then → WB_MEM.
- WB_MEM: `reg_write`, `mem_to_reg` = 1, `reg_dst` = 0 → FETCH.
- MEM_WR: `mem_write`, `iord` = 1. Waits for `mem_ready`, then → FETCH.
- BRANCH:
  - `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = SUB_EQ/SUB_NE.
  - `pc_write_cond` = 1, `pc_src` = 1, `branch_ne` = (opcode == 5).
  - → FETCH.
- JUMP: `pc_write`, `pc_src` = 2. For jal also `reg_write`, `reg_dst` = 2, `mem_to_reg` = 2. → FETCH.
- JUMP_REG: `pc_write`, `pc_src` = 3 → FETCH.
- sw never asserts `reg_write`.

## Timing
- State is registered. Outputs are combinational from state and opcode/funct.
- `ir_write`/`pc_write` in FETCH are gated by `mem_ready`.
- Reset: async to FETCH. While `rst_n` = 0, all outputs are 0, including `mem_read`. This also applies mid-wait (MEM_RD/MEM_WR): the request is dropped the same instant, with no write-back.
- Latency with zero waits (N waits add N cycles per memory state):
  - beq/bne/j/jal/jr: 3 cycles.
  - R, I-arith, sw: 4 cycles.
  - lw: 5 cycles.
- Wait handshake:
  - `mem_read`/`mem_write`/`iord` are held stable until the `mem_ready` cycle.
  - `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- `instr_done` is asserted in the final state's cycle: WB_*, MEM_WR ready cycle, BRANCH, JUMP, JUMP_REG, illegal DECODE.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode/funct localparams;
  - ALU code constants;
  - state enum;
  - `mem_to_reg`/`reg_dst`/`alu_src_b`/`pc_src` select encodings.
- Sub-module `ctrl_decode`: pure combinational map from state, opcode and funct to the output bundle.
- The top holds the state register and next-state logic.

## Test plan
- Reset deasserted; FETCH with `mem_ready` high on the 1st cycle; opcode 0, funct 0x20 → FETCH, DECODE, EXEC_R (`alu_op` = 15), WB_ALU (`reg_write` = 1, `reg_dst` = 1), `instr_done` on cycle 4.
- lw (35) with `mem_ready` low for 2 cycles in MEM_RD → `mem_read` = 1, `iord` = 1 held for 3 cycles; WB_MEM `mem_to_reg` = 1; total 7 cycles.
- bne (5) → BRANCH: `pc_write_cond` = 1, `branch_ne` = 1, `alu_op` = 6, `pc_src` = 1; 3 cycles.
- jal (3) → JUMP: `pc_write` = 1, `pc_src` = 2, `reg_write` = 1, `reg_dst` = 2, `mem_to_reg` = 2.
- opcode 63 → `illegal` and `instr_done` pulse in DECODE, no `reg_write`, `mem_write` or `pc_write` asserted; next cycle FETCH.
- `rst_n` low during MEM_WR wait → `mem_write` drops to 0 immediately; after release, FETCH with `mem_read` = 1.
